secure_keystore_v2: RTL and testbench

SECURE_KEYSTORE_V2 -- requirements
Module: secure_keystore_v2

---
 rtl/secure_keystore_v2.sv | 178 +++++++++++++++++
 tb/tb_secure_keystore_v2.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/secure_keystore_v2.sv
// Password-gated key store: bus-writable key slots that are never bus-readable,
// with sticky per-slot write locks and a timed lockout after repeated bad passwords.
module secure_keystore_v2 #(
  parameter int          DATA_W      = 32,
  parameter int          NUM_SLOTS   = 4,
  parameter logic [31:0] UNLOCK_KEY  = 32'hA5C3_5A3C,
  parameter int          MAX_FAILS   = 3,
  parameter int          LOCKOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [7:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic [2:0]        key_sel,
  output logic [DATA_W-1:0] key_out,
  output logic              unlocked,
  output logic              lockout
);

  localparam int LCW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam logic [DATA_W-1:0] KEY_CMP = DATA_W'(UNLOCK_KEY);
  localparam logic [7:0] ADDR_UNLOCK = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_RELOCK = 8'h02;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_e;

  state_e            state_r, state_nxt_s;
  logic [7:0]        fail_cnt_r, fail_cnt_nxt_s;
  logic [LCW-1:0]    lo_cnt_r, lo_cnt_nxt_s;
  logic [7:0]        slot_lock_r, slot_lock_nxt_s;
  // Sized to the full 3-bit select space; slots at or above NUM_SLOTS are never written.
  logic [DATA_W-1:0] slot_r [8];
  logic              key_we_s;
  logic              accept_s, addr_key_s, addr_lock_s, key_sel_ok_s;
  logic [2:0]        idx_s;
  logic [31:0]       status_s;
  logic              rsp_valid_nxt_s, rsp_err_nxt_s;
  logic [DATA_W-1:0] rsp_rdata_nxt_s;
  logic              rsp_valid_r, rsp_err_r;
  logic [DATA_W-1:0] rsp_rdata_r, key_out_r;

  assign req_ready    = (state_r != ST_LOCKOUT);
  assign unlocked     = (state_r == ST_UNLOCKED);
  assign lockout      = (state_r == ST_LOCKOUT);
  assign accept_s     = req_valid && req_ready;
  assign idx_s        = req_addr[2:0];
  assign addr_key_s   = (req_addr[7:4] == 4'h1) && (req_addr[3:0] < 4'(NUM_SLOTS));
  assign addr_lock_s  = (req_addr[7:4] == 4'h2) && (req_addr[3:0] < 4'(NUM_SLOTS));
  assign key_sel_ok_s = ({1'b0, key_sel} < 4'(NUM_SLOTS));
  assign status_s     = {14'd0, lockout, unlocked, fail_cnt_r, slot_lock_r};
  assign rsp_valid    = rsp_valid_r;
  assign rsp_rdata    = rsp_rdata_r;
  assign rsp_err      = rsp_err_r;
  assign key_out      = key_out_r;

  // Next-state, register side effects and response for the accepted request.
  always_comb begin
    state_nxt_s     = state_r;
    fail_cnt_nxt_s  = fail_cnt_r;
    lo_cnt_nxt_s    = lo_cnt_r;
    slot_lock_nxt_s = slot_lock_r;
    key_we_s        = 1'b0;
    rsp_valid_nxt_s = 1'b0;
    rsp_err_nxt_s   = 1'b0;
    rsp_rdata_nxt_s = '0;
    if (state_r == ST_LOCKOUT) begin
      if (lo_cnt_r == LCW'(LOCKOUT_CYC - 1)) begin
        state_nxt_s    = ST_LOCKED;
        fail_cnt_nxt_s = 8'd0;
        lo_cnt_nxt_s   = '0;
      end else begin
        lo_cnt_nxt_s = lo_cnt_r + LCW'(1);
      end
    end else if (accept_s) begin
      rsp_valid_nxt_s = 1'b1;
      if (addr_key_s) begin
        // Keys are write-only; a read is always refused with zero data.
        if (req_write && (state_r == ST_UNLOCKED) && !slot_lock_r[idx_s]) begin
          key_we_s = 1'b1;
        end else begin
          rsp_err_nxt_s = 1'b1;
        end
      end else if (addr_lock_s) begin
        if (!req_write || (state_r != ST_UNLOCKED)) begin
          rsp_err_nxt_s = 1'b1;
        end else if (req_wdata[0]) begin
          slot_lock_nxt_s[idx_s] = 1'b1;
        end else begin
          slot_lock_nxt_s = slot_lock_r;
        end
      end else begin
        case (req_addr)
          ADDR_UNLOCK: begin
            if (!req_write) begin
              rsp_err_nxt_s = 1'b1;
            end else if (state_r == ST_LOCKED) begin
              if (req_wdata == KEY_CMP) begin
                state_nxt_s    = ST_UNLOCKED;
                fail_cnt_nxt_s = 8'd0;
              end else begin
                rsp_err_nxt_s  = 1'b1;
                fail_cnt_nxt_s = fail_cnt_r + 8'd1;
                if (fail_cnt_r == 8'(MAX_FAILS - 1)) begin
                  state_nxt_s  = ST_LOCKOUT;
                  lo_cnt_nxt_s = '0;
                end else begin
                  state_nxt_s = ST_LOCKED;
                end
              end
            end else begin
              state_nxt_s = state_r;
            end
          end
          ADDR_STATUS: begin
            if (req_write) begin
              rsp_err_nxt_s = 1'b1;
            end else begin
              rsp_rdata_nxt_s = DATA_W'(status_s);
            end
          end
          ADDR_RELOCK: begin
            if (!req_write) begin
              rsp_err_nxt_s = 1'b1;
            end else if ((state_r == ST_UNLOCKED) && req_wdata[0]) begin
              state_nxt_s = ST_LOCKED;
            end else begin
              state_nxt_s = state_r;
            end
          end
          default: rsp_err_nxt_s = 1'b1;
        endcase
      end
    end else begin
      rsp_valid_nxt_s = 1'b0;
    end
  end

  // State, key storage and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_LOCKED;
      fail_cnt_r  <= 8'd0;
      lo_cnt_r    <= '0;
      slot_lock_r <= 8'd0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= '0;
      key_out_r   <= '0;
      for (int i = 0; i < 8; i++) begin
        slot_r[i] <= '0;
      end
    end else begin
      state_r     <= state_nxt_s;
      fail_cnt_r  <= fail_cnt_nxt_s;
      lo_cnt_r    <= lo_cnt_nxt_s;
      slot_lock_r <= slot_lock_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
      key_out_r   <= key_sel_ok_s ? slot_r[key_sel] : '0;
      if (key_we_s) begin
        slot_r[idx_s] <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_secure_keystore_v2.sv
// Directed self-checking bench for secure_keystore_v2 at default parameters.
module tb_secure_keystore_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [2:0]  key_sel;
  logic [31:0] key_out;
  logic        unlocked, lockout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd;
  logic        er;
  int          cyc;

  always #5 clk = ~clk;

  secure_keystore_v2 dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .key_sel(key_sel), .key_out(key_out),
    .unlocked(unlocked), .lockout(lockout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus transaction; returns the response sampled just after the accepting edge.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      output logic [31:0] rdo, output logic ero);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    rdo = rsp_rdata;
    ero = rsp_err;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00;
    req_wdata = 32'h0; key_sel = 3'd0;
    cycles(3);
    @(negedge clk); rst = 1'b0;
    cycles(1);
    chk("rst_unlocked", {31'd0, unlocked}, 32'd0);
    chk("rst_lockout", {31'd0, lockout}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_keyout", key_out, 32'h0);
    chk("rst_rspvalid", {31'd0, rsp_valid}, 32'd0);

    xfer(1'b0, 8'h01, 32'h0, rd, er);
    chk("status0_rd", rd, 32'h0);
    chk("status0_err", {31'd0, er}, 32'd0);
    cycles(1);
    chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    chk("rsp_idle_rdata", rsp_rdata, 32'h0);

    xfer(1'b1, 8'h11, 32'hDEADBEEF, rd, er);
    chk("key_wr_locked_err", {31'd0, er}, 32'd1);
    key_sel = 3'd1;
    cycles(2);
    chk("key_locked_out", key_out, 32'h0);

    xfer(1'b1, 8'h00, 32'hA5C35A3C, rd, er);
    chk("unlock_err", {31'd0, er}, 32'd0);
    chk("unlock_state", {31'd0, unlocked}, 32'd1);
    xfer(1'b0, 8'h01, 32'h0, rd, er);
    chk("status_unl", rd, 32'h0001_0000);

    xfer(1'b1, 8'h11, 32'hDEADBEEF, rd, er);
    chk("key1_wr_err", {31'd0, er}, 32'd0);
    chk("key1_not_yet", key_out, 32'h0);
    cycles(1);
    chk("key1_visible", key_out, 32'hDEADBEEF);
    xfer(1'b0, 8'h11, 32'h0, rd, er);
    chk("key1_rd_data", rd, 32'h0);
    chk("key1_rd_err", {31'd0, er}, 32'd1);

    xfer(1'b1, 8'h00, 32'h0, rd, er);
    chk("unlock_noop_err", {31'd0, er}, 32'd0);
    chk("unlock_noop_st", {31'd0, unlocked}, 32'd1);

    xfer(1'b1, 8'h21, 32'h0, rd, er);
    chk("slk_w0_err", {31'd0, er}, 32'd0);
    xfer(1'b0, 8'h01, 32'h0, rd, er);
    chk("slk_w0_status", rd, 32'h0001_0000);
    xfer(1'b1, 8'h21, 32'h1, rd, er);
    chk("slk_w1_err", {31'd0, er}, 32'd0);
    xfer(1'b0, 8'h01, 32'h0, rd, er);
    chk("slk_w1_status", rd, 32'h0001_0002);
    xfer(1'b1, 8'h11, 32'h1, rd, er);
    chk("key1_locked_err", {31'd0, er}, 32'd1);
    cycles(2);
    chk("key1_kept", key_out, 32'hDEADBEEF);

    xfer(1'b1, 8'h10, 32'h12345678, rd, er);
    chk("key0_wr_err", {31'd0, er}, 32'd0);
    key_sel = 3'd0;
    cycles(2);
    chk("key0_out", key_out, 32'h12345678);
    key_sel = 3'd5;
    cycles(2);
    chk("keysel_oob", key_out, 32'h0);

    xfer(1'b1, 8'h14, 32'h1, rd, er);
    chk("illegal_key4", {31'd0, er}, 32'd1);
    xfer(1'b1, 8'h24, 32'h1, rd, er);
    chk("illegal_slk4", {31'd0, er}, 32'd1);
    xfer(1'b0, 8'h03, 32'h0, rd, er);
    chk("illegal_03", {31'd0, er}, 32'd1);
    xfer(1'b1, 8'h01, 32'h0, rd, er);
    chk("status_wr_err", {31'd0, er}, 32'd1);
    xfer(1'b0, 8'h00, 32'h0, rd, er);
    chk("unlock_rd_err", {31'd0, er}, 32'd1);
    xfer(1'b0, 8'h21, 32'h0, rd, er);
    chk("slk_rd_err", {31'd0, er}, 32'd1);

    xfer(1'b1, 8'h02, 32'h0, rd, er);
    chk("relock0_err", {31'd0, er}, 32'd0);
    chk("relock0_st", {31'd0, unlocked}, 32'd1);
    xfer(1'b1, 8'h02, 32'h1, rd, er);
    chk("relock1_err", {31'd0, er}, 32'd0);
    chk("relock1_st", {31'd0, unlocked}, 32'd0);
    xfer(1'b0, 8'h01, 32'h0, rd, er);
    chk("status_relocked", rd, 32'h0000_0002);
    xfer(1'b1, 8'h02, 32'h1, rd, er);
    chk("relock_locked_err", {31'd0, er}, 32'd0);
    xfer(1'b1, 8'h22, 32'h1, rd, er);
    chk("slk_locked_err", {31'd0, er}, 32'd1);

    xfer(1'b1, 8'h00, 32'h0, rd, er);
    chk("bad1_err", {31'd0, er}, 32'd1);
    xfer(1'b0, 8'h01, 32'h0, rd, er);
    chk("status_fail1", rd, 32'h0000_0102);
    xfer(1'b1, 8'h00, 32'h0, rd, er);
    chk("bad2_err", {31'd0, er}, 32'd1);
    chk("bad2_nolock", {31'd0, lockout}, 32'd0);
    xfer(1'b1, 8'h00, 32'h0, rd, er);
    chk("bad3_err", {31'd0, er}, 32'd1);
    chk("bad3_lockout", {31'd0, lockout}, 32'd1);
    chk("bad3_ready", {31'd0, req_ready}, 32'd0);
    cyc = 0;
    while (lockout && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("lockout_len", 32'(cyc), 32'd16);
    chk("post_lo_ready", {31'd0, req_ready}, 32'd1);
    xfer(1'b0, 8'h01, 32'h0, rd, er);
    chk("status_post_lo", rd, 32'h0000_0002);
    chk("status_post_err", {31'd0, er}, 32'd0);

    for (int i = 0; i < 3; i++) xfer(1'b1, 8'h00, 32'h5, rd, er);
    cycles(3);
    chk("pre_rst_lockout", {31'd0, lockout}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_lo_lockout", {31'd0, lockout}, 32'd0);
    chk("rst_lo_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;

    xfer(1'b1, 8'h00, 32'hA5C35A3C, rd, er);
    chk("reunlock_st", {31'd0, unlocked}, 32'd1);
    key_sel = 3'd0;
    cycles(1);
    chk("slot0_cleared", key_out, 32'h0);
    xfer(1'b1, 8'h10, 32'hCAFE0001, rd, er);
    cycles(1);
    chk("slot0_new", key_out, 32'hCAFE0001);
    xfer(1'b0, 8'h01, 32'h0, rd, er);
    #2 rst = 1'b1;
    #1;
    chk("rst_unl_state", {31'd0, unlocked}, 32'd0);
    chk("rst_drop_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_keyout0", key_out, 32'h0);
    @(negedge clk); rst = 1'b0;
    cycles(2);
    chk("rst_slot0", key_out, 32'h0);
    xfer(1'b0, 8'h01, 32'h0, rd, er);
    chk("rst_status", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
